// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer run/stop controller and counter chain.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } timer_state_e;

  localparam int TIMER_CLEAR_CYCLES_DEF = 2;

endpackage

// File: rtl/timer_btn_edge.sv
// Rising-edge detector for one debounced button level; history resets high so a
// button held through reset produces no edge until released and pressed again.
module timer_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_edge
);

  logic btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b1;
    else        btn_q <= btn;
  end

  assign btn_edge = btn & ~btn_q;

endmodule

// File: rtl/timer_run_ctrl.sv
// Run/stop controller: turns button edges and the full-scale pulse into the
// pause/clear controls for the counter chain, plus lap freeze and overflow flags.
module timer_run_ctrl
  import timer_pkg::*;
#(
  parameter int CLEAR_CYCLES = TIMER_CLEAR_CYCLES_DEF
) (
  input  logic       sys_clk,
  input  logic       int_reset_b,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       timer_max_reached,
  output logic       timer_pause,
  output logic       timer_clear,
  output logic       lap_hold,
  output logic       timer_overflow,
  output logic [1:0] timer_state
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  logic ss_edge, clr_edge, lap_edge;

  timer_btn_edge u_ss_edge  (.clk(sys_clk), .rst_n(int_reset_b), .btn(btn_start_stop), .btn_edge(ss_edge));
  timer_btn_edge u_clr_edge (.clk(sys_clk), .rst_n(int_reset_b), .btn(btn_clear),      .btn_edge(clr_edge));
  timer_btn_edge u_lap_edge (.clk(sys_clk), .rst_n(int_reset_b), .btn(btn_lap),        .btn_edge(lap_edge));

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lap_q, lap_d;
  logic             ovf_q, ovf_d;
  logic             pause_q, clear_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (clr_edge)     state_d = CLEAR;
        else if (ss_edge) state_d = RUN;
      end
      RUN: begin
        if (clr_edge) begin
          state_d = CLEAR;
        end else if (timer_max_reached) begin
          state_d = PAUSE;
          ovf_d   = 1'b1;
        end else if (ss_edge) begin
          state_d = PAUSE;
        end else if (lap_edge) begin
          lap_d = ~lap_q;
        end
      end
      PAUSE: begin
        if (clr_edge)               state_d = CLEAR;
        else if (ss_edge && !ovf_q) state_d = RUN;
        if (lap_edge) lap_d = 1'b0;
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Entry into CLEAR from any state arms the hold counter and drops the flags.
    if (state_q != CLEAR && state_d == CLEAR) begin
      cnt_d = CNT_W'(CLEAR_CYCLES - 1);
      lap_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pause_q <= 1'b1;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      pause_q <= (state_d == IDLE) || (state_d == PAUSE);
      clear_q <= (state_d == CLEAR);
    end
  end

  assign timer_pause    = pause_q;
  assign timer_clear    = clear_q;
  assign lap_hold       = lap_q;
  assign timer_overflow = ovf_q;
  assign timer_state    = state_q;

endmodule
